// File: rtl/pc_unit_if.sv
// Program-counter unit control/status bundle.
// The master side drives the op stream; the slave side is the PC unit.
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             ena;
    logic [2:0]       op;
    logic [WIDTH-1:0] data_in;
    logic             clr_err;
    logic [WIDTH-1:0] data_out;
    logic             ras_full;
    logic             ras_empty;
    logic             ras_err;
    logic             misalign;

    modport master (
        output ena,
        output op,
        output data_in,
        output clr_err,
        input  data_out,
        input  ras_full,
        input  ras_empty,
        input  ras_err,
        input  misalign
    );

    modport slave (
        input  ena,
        input  op,
        input  data_in,
        input  clr_err,
        output data_out,
        output ras_full,
        output ras_empty,
        output ras_err,
        output misalign
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with branch/jump/call/return and a circular
// return-address stack that overwrites its oldest entry on overflow.
module pc_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               STEP      = 4,
    parameter int               RAS_DEPTH = 4
) (
    input logic     clk,
    input logic     rst,
    pc_unit_if.slave bus
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] STEP_MASK = WIDTH'(STEP - 1);
    localparam logic [CW-1:0]    FULL_CNT  = CW'(RAS_DEPTH);

    typedef enum logic [2:0] {
        OP_SEQ    = 3'd0,
        OP_BRANCH = 3'd1,
        OP_JUMP   = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4,
        OP_LOAD   = 3'd5
    } op_e;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_n;
    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]    top;
    logic [PW-1:0]    top_inc;
    logic [CW-1:0]    count;
    logic             err_q;

    logic is_br;
    logic is_jmp;
    logic is_call;
    logic is_ret;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic err;

    assign pc_seq  = pc + STEP_W;
    assign top_inc = top + PW'(1);
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);

    assign is_br   = (bus.op == OP_BRANCH);
    assign is_jmp  = (bus.op == OP_JUMP) || (bus.op == OP_LOAD);
    assign is_call = (bus.op == OP_CALL);
    assign is_ret  = (bus.op == OP_RET);

    // SEQ and the reserved codes share the default path.
    always_comb begin
        pc_n = pc_seq;
        push = 1'b0;
        pop  = 1'b0;
        err  = 1'b0;
        unique case (1'b1)
            is_br: begin
                pc_n = pc + bus.data_in;
            end
            is_jmp: begin
                pc_n = bus.data_in;
            end
            is_call: begin
                pc_n = bus.data_in;
                push = 1'b1;
                err  = full;
            end
            is_ret: begin
                if (empty) begin
                    err = 1'b1;
                end else begin
                    pc_n = stack[top];
                    pop  = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= RESET_VEC;
            top   <= '0;
            count <= '0;
            err_q <= 1'b0;
        end else begin
            if (bus.ena) begin
                pc <= pc_n;
                if (push) begin
                    top <= top_inc;
                    if (!full) count <= count + CW'(1);
                end else if (pop) begin
                    top   <= top - PW'(1);
                    count <= count - CW'(1);
                end
            end
            // A fresh error beats a simultaneous clear.
            if (bus.ena && err) begin
                err_q <= 1'b1;
            end else if (bus.clr_err) begin
                err_q <= 1'b0;
            end
        end
    end

    // Stack storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (bus.ena && push) begin
            stack[top_inc] <= pc_seq;
        end
    end

    assign bus.data_out  = pc;
    assign bus.ras_full  = full;
    assign bus.ras_empty = empty;
    assign bus.ras_err   = err_q;
    assign bus.misalign  = |(pc & STEP_MASK);

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, reset sequence and
// randomized ops checked against a queue-based reference model.
module tb_pc_unit;

    localparam int DEPTH = 4;

    localparam logic [2:0] SEQ  = 3'd0;
    localparam logic [2:0] BR   = 3'd1;
    localparam logic [2:0] JMP  = 3'd2;
    localparam logic [2:0] CALL = 3'd3;
    localparam logic [2:0] RET  = 3'd4;
    localparam logic [2:0] LOAD = 3'd5;

    typedef struct {
        logic        ena;
        logic [2:0]  op;
        logic [31:0] din;
        logic        clr;
        logic [31:0] pc;
        logic        emp;
        logic        full;
        logic        err;
        logic        mis;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    vec_t tv[$];

    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic        m_err;

    pc_unit_if #(.WIDTH(32)) bus ();

    pc_unit #(
        .WIDTH    (32),
        .RESET_VEC(32'h0000_0000),
        .STEP     (4),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] pc,
                       input logic emp, input logic full,
                       input logic err, input logic mis);
        total++;
        if (bus.data_out !== pc || bus.ras_empty !== emp ||
            bus.ras_full !== full || bus.ras_err !== err ||
            bus.misalign !== mis) begin
            bad++;
            $display("FAIL %s: got pc=%h e=%b f=%b err=%b mis=%b want pc=%h e=%b f=%b err=%b mis=%b",
                     name, bus.data_out, bus.ras_empty, bus.ras_full,
                     bus.ras_err, bus.misalign, pc, emp, full, err, mis);
        end
    endtask

    task automatic add(input logic ena, input logic [2:0] op,
                       input logic [31:0] din, input logic clr,
                       input logic [31:0] pc, input logic emp,
                       input logic full, input logic err,
                       input logic mis);
        vec_t v;
        v.ena = ena; v.op = op; v.din = din; v.clr = clr;
        v.pc = pc; v.emp = emp; v.full = full; v.err = err; v.mis = mis;
        tv.push_back(v);
    endtask

    task automatic drive(input logic ena, input logic [2:0] op,
                         input logic [31:0] din, input logic clr);
        bus.ena     = ena;
        bus.op      = op;
        bus.data_in = din;
        bus.clr_err = clr;
    endtask

    // Reference: return addresses kept in a bounded queue, newest at back.
    task automatic model_step(input logic ena, input logic [2:0] op,
                              input logic [31:0] din, input logic clr);
        logic fresh;
        fresh = 1'b0;
        if (ena) begin
            case (op)
                BR:        m_pc = m_pc + din;
                JMP, LOAD: m_pc = din;
                CALL: begin
                    m_q.push_back(m_pc + 32'd4);
                    if (m_q.size() > DEPTH) begin
                        void'(m_q.pop_front());
                        fresh = 1'b1;
                    end
                    m_pc = din;
                end
                RET: begin
                    if (m_q.size() == 0) begin
                        m_pc  = m_pc + 32'd4;
                        fresh = 1'b1;
                    end else begin
                        m_pc = m_q.pop_back();
                    end
                end
                default:   m_pc = m_pc + 32'd4;
            endcase
        end
        if (fresh) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        drive(1'b0, SEQ, 32'h0, 1'b0);

        // ena op din clr | pc emp full err mis
        add(1, SEQ,  32'h0,         0, 32'h4,         1, 0, 0, 0);
        add(1, SEQ,  32'h0,         0, 32'h8,         1, 0, 0, 0);
        add(1, SEQ,  32'h0,         0, 32'hC,         1, 0, 0, 0);
        add(1, JMP,  32'h100,       0, 32'h100,       1, 0, 0, 0);
        add(1, BR,   32'hFFFF_FFF0, 0, 32'hF0,        1, 0, 0, 0);
        add(1, JMP,  32'h2000,      0, 32'h2000,      1, 0, 0, 0);
        add(0, JMP,  32'h5000,      0, 32'h2000,      1, 0, 0, 0);
        add(1, JMP,  32'h10,        0, 32'h10,        1, 0, 0, 0);
        add(1, CALL, 32'h400,       0, 32'h400,       0, 0, 0, 0);
        add(1, CALL, 32'h800,       0, 32'h800,       0, 0, 0, 0);
        add(1, RET,  32'h0,         0, 32'h404,       0, 0, 0, 0);
        add(1, RET,  32'h0,         0, 32'h14,        1, 0, 0, 0);
        add(1, RET,  32'h0,         0, 32'h18,        1, 0, 1, 0);
        add(1, SEQ,  32'h0,         1, 32'h1C,        1, 0, 0, 0);
        add(1, JMP,  32'h3,         0, 32'h3,         1, 0, 0, 1);
        add(1, RET,  32'h0,         0, 32'h7,         1, 0, 1, 1);
        add(0, RET,  32'h0,         1, 32'h7,         1, 0, 0, 1);
        add(1, RET,  32'h0,         1, 32'hB,         1, 0, 1, 1);
        add(1, SEQ,  32'h0,         1, 32'hF,         1, 0, 0, 1);
        add(1, JMP,  32'h0,         0, 32'h0,         1, 0, 0, 0);
        add(1, CALL, 32'h100,       0, 32'h100,       0, 0, 0, 0);
        add(1, CALL, 32'h200,       0, 32'h200,       0, 0, 0, 0);
        add(1, CALL, 32'h300,       0, 32'h300,       0, 0, 0, 0);
        add(1, CALL, 32'h400,       0, 32'h400,       0, 1, 0, 0);
        add(1, CALL, 32'h500,       0, 32'h500,       0, 1, 1, 0);
        add(1, RET,  32'h0,         0, 32'h404,       0, 0, 1, 0);
        add(1, RET,  32'h0,         0, 32'h304,       0, 0, 1, 0);
        add(1, RET,  32'h0,         0, 32'h204,       0, 0, 1, 0);
        add(1, RET,  32'h0,         0, 32'h104,       1, 0, 1, 0);
        add(1, RET,  32'h0,         0, 32'h108,       1, 0, 1, 0);
        add(1, SEQ,  32'h0,         1, 32'h10C,       1, 0, 0, 0);
        add(1, LOAD, 32'h1234_5670, 0, 32'h1234_5670, 1, 0, 0, 0);
        add(1, 3'd6, 32'hFFFF_FFFF, 0, 32'h1234_5674, 1, 0, 0, 0);
        add(1, 3'd7, 32'hFFFF_FFFF, 0, 32'h1234_5678, 1, 0, 0, 0);
        add(1, JMP,  32'hFFFF_FFF0, 0, 32'hFFFF_FFF0, 1, 0, 0, 0);
        add(1, BR,   32'h20,        0, 32'h10,        1, 0, 0, 0);
        add(1, JMP,  32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 0, 0, 0);
        add(1, SEQ,  32'h0,         0, 32'h0,         1, 0, 0, 0);

        #3;
        chk("reset_state", 32'h0, 1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tv[i]) begin
            drive(tv[i].ena, tv[i].op, tv[i].din, tv[i].clr);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), tv[i].pc, tv[i].emp,
                tv[i].full, tv[i].err, tv[i].mis);
        end

        // Asynchronous reset between edges during a call sequence.
        drive(1, JMP, 32'h40, 0);
        @(posedge clk); #1;
        drive(1, CALL, 32'h900, 0);
        @(posedge clk); #1;
        chk("pre_rst_call", 32'h900, 0, 0, 0, 0);
        drive(1, CALL, 32'hA00, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst", 32'h0, 1, 0, 0, 0);
        @(posedge clk); #1;
        chk("rst_held_edge", 32'h0, 1, 0, 0, 0);
        drive(1, SEQ, 32'h0, 0);
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_seq", 32'h4, 1, 0, 0, 0);
        drive(1, RET, 32'h0, 0);
        @(posedge clk); #1;
        chk("post_rst_ret", 32'h8, 1, 0, 1, 0);

        // Randomized run against the reference model.
        rst = 1'b0;
        #2;
        rst = 1'b1;
        m_pc  = 32'h0;
        m_err = 1'b0;
        m_q.delete();
        for (int n = 0; n < 3000; n++) begin
            logic        r_ena;
            logic [2:0]  r_op;
            logic [31:0] r_din;
            logic        r_clr;
            r_ena = ($urandom_range(0, 7) != 0);
            r_op  = 3'($urandom_range(0, 7));
            r_din = $urandom;
            if ($urandom_range(0, 3) != 0) r_din = r_din & 32'h0000_0FFC;
            r_clr = ($urandom_range(0, 5) == 0);
            drive(r_ena, r_op, r_din, r_clr);
            model_step(r_ena, r_op, r_din, r_clr);
            @(posedge clk); #1;
            chk($sformatf("rand%0d", n), m_pc, (m_q.size() == 0),
                (m_q.size() == DEPTH), m_err, (m_pc[1:0] != 2'b00));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
